// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes and transmit-path outputs of the UART TX arbiter.
// The master side is the requesters and the transmitter; the slave side is the arbiter.
interface uart_tx_arbiter_if;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_enable;
  logic [1:0]  grant;
  logic        lock;
  logic        busy;

  modport master (
    output req_data, req_valid, req_last,
    input  req_ready, uart_tx_data, uart_tx_enable,
    input  grant, lock, busy
  );

  modport slave (
    input  req_data, req_valid, req_last,
    output req_ready, uart_tx_data, uart_tx_enable,
    output grant, lock, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART transmit path
// between four byte-stream requesters, pacing frames with a frame-time counter.
module uart_tx_arbiter #(
  parameter logic [31:0] CLK_FREQ   = 32'd50_000_000,
  parameter logic [31:0] UART_BAUD  = 32'd115200,
  parameter logic [3:0]  FRAME_BITS = 4'd10,
  parameter logic [3:0]  GUARD_BITS = 4'd1
) (
  input logic clk_in,
  input logic rst_n_in,
  uart_tx_arbiter_if.slave bus
);
  localparam logic [31:0] BAUD_CNT  = CLK_FREQ / UART_BAUD;
  localparam logic [31:0] FRAME_CYC =
    BAUD_CNT * (32'(FRAME_BITS) + 32'(GUARD_BITS));
  localparam logic [19:0] CNT_LOAD  = 20'(FRAME_CYC - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [19:0] cnt;
  logic [1:0]  ptr;
  logic [1:0]  gnt;
  logic [1:0]  pick;
  logic        lck;
  logic        hit;
  logic        accept;
  logic [7:0]  data;

  // Reverse scan so the earliest candidate after ptr wins.
  always_comb begin
    pick = gnt;
    hit  = 1'b0;
    if (lck) begin
      hit = bus.req_valid[gnt];
    end else begin
      for (int k = 4; k >= 1; k--) begin
        if (bus.req_valid[ptr + 2'(k)]) begin
          hit  = 1'b1;
          pick = ptr + 2'(k);
        end
      end
    end
  end

  // No handshake may be offered while reset is held.
  assign accept = (state == IDLE) & hit & rst_n_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SEND;
      SEND:    state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[pick] = 1'b1;
    bus.uart_tx_enable = (state == SEND);
    bus.busy           = (state != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data <= '0;
      gnt  <= '0;
      ptr  <= 2'd3;
      lck  <= 1'b0;
      cnt  <= '0;
    end else begin
      if (accept) begin
        data <= bus.req_data[{pick, 3'b000} +: 8];
        gnt  <= pick;
        ptr  <= pick;
        lck  <= ~bus.req_last[pick];
      end
      if (state == SEND) begin
        cnt <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 20'd1;
      end
    end
  end

  assign bus.uart_tx_data = data;
  assign bus.grant        = gnt;
  assign bus.lock         = lck;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table and random traffic on a short-frame
// instance, hand sequences for timing and mid-frame reset on a default instance.
module tb_uart_tx_arbiter;
  localparam int FC_S = 100;
  localparam int FC_D = 4774;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if sif ();
  uart_tx_arbiter_if dif ();

  uart_tx_arbiter #(
    .CLK_FREQ  (32'd1000),
    .UART_BAUD (32'd100),
    .FRAME_BITS(4'd10),
    .GUARD_BITS(4'd0)
  ) u_small (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (sif.slave)
  );

  uart_tx_arbiter u_dflt (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (dif.slave)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  ready;
    logic [1:0]  gnt;
    logic        lck;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [3:0] v, logic [3:0] l, logic [31:0] d,
                              logic [3:0] r, logic [1:0] g, logic k);
    vec_t t;
    t.valid = v;
    t.last  = l;
    t.data  = d;
    t.ready = r;
    t.gnt   = g;
    t.lck   = k;
    tbl.push_back(t);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(string nm, logic [3:0] r, logic e,
                          logic [7:0] d, logic [1:0] g, logic k, logic b);
    chk({nm, "_ready"}, 32'(r), 32'd0);
    chk({nm, "_enable"}, 32'(e), 32'd0);
    chk({nm, "_data"}, 32'(d), 32'd0);
    chk({nm, "_grant"}, 32'(g), 32'd0);
    chk({nm, "_lock"}, 32'(k), 32'd0);
    chk({nm, "_busy"}, 32'(b), 32'd0);
  endtask

  task automatic run_table();
    logic [7:0] eb;
    for (int j = 0; j < tbl.size(); j++) begin
      @(posedge clk);
      #1;
      sif.req_valid = tbl[j].valid;
      sif.req_last  = tbl[j].last;
      sif.req_data  = tbl[j].data;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", j), 32'(sif.req_ready), 32'(tbl[j].ready));
      chk($sformatf("tbl%0d_idle", j), 32'(sif.busy), 32'd0);
      if (tbl[j].ready != 4'd0) begin
        eb = 8'(tbl[j].data >> (8 * tbl[j].gnt));
        @(posedge clk);
        #1;
        sif.req_valid = '0;
        @(negedge clk);
        chk($sformatf("tbl%0d_en", j), 32'(sif.uart_tx_enable), 32'd1);
        chk($sformatf("tbl%0d_data", j), 32'(sif.uart_tx_data), 32'(eb));
        chk($sformatf("tbl%0d_grant", j), 32'(sif.grant), 32'(tbl[j].gnt));
        chk($sformatf("tbl%0d_lock", j), 32'(sif.lock), 32'(tbl[j].lck));
        chk($sformatf("tbl%0d_busy", j), 32'(sif.busy), 32'd1);
        repeat (FC_S) @(negedge clk);
        chk($sformatf("tbl%0d_busy_end", j), 32'(sif.busy), 32'd1);
        chk($sformatf("tbl%0d_en_end", j), 32'(sif.uart_tx_enable), 32'd0);
        @(negedge clk);
        chk($sformatf("tbl%0d_free", j), 32'(sif.busy), 32'd0);
      end else begin
        repeat (10) @(negedge clk);
        chk($sformatf("tbl%0d_stall_ready", j), 32'(sif.req_ready), 32'd0);
        chk($sformatf("tbl%0d_stall_busy", j), 32'(sif.busy), 32'd0);
        chk($sformatf("tbl%0d_stall_lock", j), 32'(sif.lock), 32'(tbl[j].lck));
        chk($sformatf("tbl%0d_stall_grant", j), 32'(sif.grant), 32'(tbl[j].gnt));
        sif.req_valid = '0;
      end
    end
  endtask

  // Timeline model: a byte accepted in cycle n is strobed in n+1 and the
  // line is free again from cycle n+2+FC_S.
  task automatic run_random(int ncyc);
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] dat;
    logic [7:0]  md;
    logic        lk;
    int          ptr;
    int          g;
    int          acc;
    int          nfree;
    int          sel;
    logic [3:0]  er;
    v = '0;
    l = '0;
    dat = '0;
    md = '0;
    lk = 1'b0;
    ptr = 3;
    g = 0;
    acc = -1000;
    nfree = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && $urandom_range(0, 5) == 0) begin
          v[i] = 1'b1;
          l[i] = ($urandom_range(0, 2) != 0);
          dat[8*i +: 8] = 8'($urandom);
        end
      end
      sif.req_valid = v;
      sif.req_last  = l;
      sif.req_data  = dat;
      @(negedge clk);
      sel = -1;
      if (n >= nfree) begin
        if (lk) begin
          if (v[g]) sel = g;
        end else begin
          for (int k = 1; k <= 4; k++) begin
            if (sel < 0 && v[(ptr + k) % 4]) sel = (ptr + k) % 4;
          end
        end
      end
      er = (sel >= 0) ? 4'(1 << sel) : 4'd0;
      chk("rnd_ready", 32'(sif.req_ready), 32'(er));
      chk("rnd_enable", 32'(sif.uart_tx_enable), 32'(n == acc + 1));
      chk("rnd_data", 32'(sif.uart_tx_data), 32'(md));
      chk("rnd_grant", 32'(sif.grant), 32'(g));
      chk("rnd_lock", 32'(sif.lock), 32'(lk));
      chk("rnd_busy", 32'(sif.busy), 32'(n > acc && n < nfree));
      if (sel >= 0) begin
        ptr = sel;
        g = sel;
        lk = !l[sel];
        md = dat[8*sel +: 8];
        acc = n;
        nfree = n + 2 + FC_S;
        v[sel] = 1'b0;
      end
    end
    sif.req_valid = '0;
  endtask

  initial begin
    int nb;
    int np;
    int pc[2];
    int pg[2];
    int pd[2];
    sif.req_valid = '0;
    sif.req_last  = '0;
    sif.req_data  = '0;
    dif.req_valid = '0;
    dif.req_last  = '0;
    dif.req_data  = '0;

    add(4'b0100, 4'b0100, 32'h005A_0000, 4'b0100, 2'd2, 1'b0);
    add(4'b1111, 4'b1111, 32'h4332_2110, 4'b1000, 2'd3, 1'b0);
    add(4'b1111, 4'b1111, 32'h4332_2110, 4'b0001, 2'd0, 1'b0);
    add(4'b1111, 4'b1111, 32'h4332_2110, 4'b0010, 2'd1, 1'b0);
    add(4'b1111, 4'b1111, 32'h4332_2110, 4'b0100, 2'd2, 1'b0);
    add(4'b1111, 4'b1111, 32'h4332_2110, 4'b1000, 2'd3, 1'b0);
    add(4'b1111, 4'b1111, 32'h4332_2110, 4'b0001, 2'd0, 1'b0);
    add(4'b0011, 4'b0001, 32'h0000_B100, 4'b0010, 2'd1, 1'b1);
    add(4'b0011, 4'b0001, 32'h0000_B200, 4'b0010, 2'd1, 1'b1);
    add(4'b0011, 4'b0011, 32'h0000_B300, 4'b0010, 2'd1, 1'b0);
    add(4'b1101, 4'b1111, 32'hD3C2_00A0, 4'b0100, 2'd2, 1'b0);
    add(4'b1001, 4'b1111, 32'hD400_00A0, 4'b1000, 2'd3, 1'b0);
    add(4'b0001, 4'b1111, 32'h0000_00A1, 4'b0001, 2'd0, 1'b0);
    add(4'b0110, 4'b0000, 32'h00C5_E500, 4'b0010, 2'd1, 1'b1);
    add(4'b1101, 4'b1111, 32'hD600_00A2, 4'b0000, 2'd1, 1'b1);
    add(4'b1111, 4'b1111, 32'hD7C7_E7A3, 4'b0010, 2'd1, 1'b0);
    add(4'b1101, 4'b1111, 32'hD8C8_00A4, 4'b0100, 2'd2, 1'b0);

    repeat (3) @(negedge clk);
    chk_zero("rst_s", sif.req_ready, sif.uart_tx_enable, sif.uart_tx_data,
             sif.grant, sif.lock, sif.busy);
    chk_zero("rst_d", dif.req_ready, dif.uart_tx_enable, dif.uart_tx_data,
             dif.grant, dif.lock, dif.busy);
    rst_n = 1'b1;

    run_table();
    run_random(6000);

    @(posedge clk);
    #1;
    dif.req_valid = 4'b0100;
    dif.req_last  = 4'b0100;
    dif.req_data  = 32'h005A_0000;
    @(negedge clk);
    chk("d_ready", 32'(dif.req_ready), 32'b0100);
    @(posedge clk);
    #1;
    dif.req_valid = '0;
    @(negedge clk);
    chk("d_enable", 32'(dif.uart_tx_enable), 32'd1);
    chk("d_data", 32'(dif.uart_tx_data), 32'h5A);
    chk("d_grant", 32'(dif.grant), 32'd2);
    chk("d_lock", 32'(dif.lock), 32'd0);
    nb = dif.busy ? 1 : 0;
    for (int c = 0; c < 6000 && dif.busy; c++) begin
      @(negedge clk);
      if (dif.busy) nb++;
    end
    chk("d_busy_len", 32'(nb), 32'(FC_D + 1));

    @(posedge clk);
    #1;
    dif.req_valid = 4'hF;
    dif.req_last  = 4'b1110;
    dif.req_data  = 32'h4332_2110;
    np = 0;
    pc = '{0, 0};
    pg = '{0, 0};
    pd = '{0, 0};
    for (int c = 0; c < 12000 && np < 2; c++) begin
      @(negedge clk);
      if (dif.uart_tx_enable) begin
        pc[np] = c;
        pg[np] = int'(dif.grant);
        pd[np] = int'(dif.uart_tx_data);
        np++;
      end
    end
    chk("d_pulses", 32'(np), 32'd2);
    chk("d_spacing", 32'(pc[1] - pc[0]), 32'(FC_D + 2));
    chk("d_grant_a", 32'(pg[0]), 32'd3);
    chk("d_data_a", 32'(pd[0]), 32'h43);
    chk("d_grant_b", 32'(pg[1]), 32'd0);
    chk("d_data_b", 32'(pd[1]), 32'h10);
    chk("d_lock_b", 32'(dif.lock), 32'd1);

    repeat (2000) @(negedge clk);
    chk("d_busy_mid", 32'(dif.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("d_arst", dif.req_ready, dif.uart_tx_enable, dif.uart_tx_data,
             dif.grant, dif.lock, dif.busy);
    dif.req_valid = 4'b0001;
    dif.req_last  = 4'b0001;
    dif.req_data  = 32'h0000_0077;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("d_post_ready", 32'(dif.req_ready), 32'b0001);
    @(negedge clk);
    dif.req_valid = '0;
    chk("d_post_enable", 32'(dif.uart_tx_enable), 32'd1);
    chk("d_post_data", 32'(dif.uart_tx_data), 32'h77);
    chk("d_post_grant", 32'(dif.grant), 32'd0);
    chk("d_post_lock", 32'(dif.lock), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
